// File: rtl/exec_pkg.sv
// Shared opcodes, the FSM state type and flag bit positions for the execute stage.
// Pure declarations: no latency and no backpressure of its own.
package exec_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_SLT = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    // Flags are packed {N,Z,C,V}.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/exec_mul.sv
// Iterative shift-and-add multiplier, low DW bits of a*b.
// Latency: done is high DW cycles after start; start is only legal while not busy.
module exec_mul #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          done,
    output logic [DW-1:0] product
);
    localparam int CW = $clog2(DW) + 1;

    logic          busy;
    logic [CW-1:0] cnt;
    logic [DW-1:0] mcand;
    logic [DW-1:0] mplier;

    assign done = busy && (cnt == CW'(DW));

    // The first partial product is folded into the start edge, so the
    // remaining DW-1 land on the following edges and done follows at DW.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy    <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            cnt     <= CW'(1);
            product <= b[0] ? a : '0;
            mcand   <= a << 1;
            mplier  <= b >> 1;
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
            end else begin
                if (mplier[0]) begin
                    product <= product + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: ALU with writeback forwarding; optional iterative MUL under EXEC_MUL_EN.
// Latency 1 (MUL: DW+1); in_ready drops only while a multiply is in flight.
module exec_stage
    import exec_pkg::*;
#(
    parameter int DW = 64,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [AW-1:0] in_rs_a,
    input  logic [AW-1:0] in_rs_b,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic [AW-1:0] in_rd,
    output logic          wb_we,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    output logic [3:0]    flags
);
    localparam int SW = $clog2(DW);

    state_t        state_q, state_d;
    logic          rdy_q;
    logic          accept;
    logic          fwd_a, fwd_b;
    logic          writes, cy, ov;
    logic [DW-1:0] opa, opb, res;
    logic [DW:0]   sum;
    logic [SW-1:0] shamt;
    logic          mul_done;
    logic [DW-1:0] mul_prod;
    logic [AW-1:0] mul_rd;

    function automatic logic [3:0] mk_flags(input logic [DW-1:0] r, input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = r[DW-1];
        f[FLAG_Z] = (r == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    assign in_ready = rdy_q && (state_q == IDLE);
    assign accept   = in_valid && in_ready;

    // r0 is never forwarded; the bank decides what reading r0 means.
    assign fwd_a = wb_we && (wb_addr != '0) && (wb_addr == in_rs_a);
    assign fwd_b = wb_we && (wb_addr != '0) && (wb_addr == in_rs_b);
    assign opa   = fwd_a ? wb_data : in_a;
    assign opb   = fwd_b ? wb_data : in_b;
    assign shamt = opb[SW-1:0];

    always_comb begin
        res    = '0;
        sum    = '0;
        cy     = 1'b0;
        ov     = 1'b0;
        writes = 1'b1;
        case (in_op)
            OP_ADD: begin
                sum = {1'b0, opa} + {1'b0, opb};
                res = sum[DW-1:0];
                cy  = sum[DW];
                ov  = (opa[DW-1] == opb[DW-1]) && (res[DW-1] != opa[DW-1]);
            end
            OP_SUB: begin
                sum = {1'b0, opa} + {1'b0, ~opb} + {{DW{1'b0}}, 1'b1};
                res = sum[DW-1:0];
                cy  = sum[DW];
                ov  = (opa[DW-1] != opb[DW-1]) && (res[DW-1] != opa[DW-1]);
            end
            OP_AND:  res = opa & opb;
            OP_OR:   res = opa | opb;
            OP_XOR:  res = opa ^ opb;
            OP_SLL:  res = opa << shamt;
            OP_SRL:  res = opa >> shamt;
            OP_SRA:  res = $signed(opa) >>> shamt;
            OP_SLT:  res = {{(DW-1){1'b0}}, ($signed(opa) < $signed(opb))};
            OP_MOV:  res = opb;
            // MUL writes back later through mul_done; 11-15 are NOPs.
            default: writes = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
`ifdef EXEC_MUL_EN
        case (state_q)
            IDLE:     if (accept && (in_op == OP_MUL)) state_d = MUL_BUSY;
            MUL_BUSY: if (mul_done) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
`else
        state_d = IDLE;
`endif
    end

`ifdef EXEC_MUL_EN
    logic mul_start;
    assign mul_start = accept && (in_op == OP_MUL);

    exec_mul #(.DW(DW)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (opa),
        .b       (opb),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mul_rd <= '0;
        else if (mul_start) mul_rd <= in_rd;
    end
`else
    assign mul_done = 1'b0;
    assign mul_prod = '0;
    assign mul_rd   = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_q   <= 1'b0;
            state_q <= IDLE;
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            flags   <= '0;
        end else begin
            rdy_q   <= 1'b1;
            state_q <= state_d;
            wb_we   <= 1'b0;
            if (mul_done) begin
                wb_we   <= 1'b1;
                wb_addr <= mul_rd;
                wb_data <= mul_prod;
                flags   <= mk_flags(mul_prod, 1'b0, 1'b0);
            end else if (accept && writes) begin
                wb_we   <= 1'b1;
                wb_addr <= in_rd;
                wb_data <= res;
                flags   <= mk_flags(res, cy, ov);
            end
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage; MUL expectations follow EXEC_MUL_EN.
module tb_exec_stage;
    localparam int DW = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_op = '0;
    logic [AW-1:0] in_rs_a = '0, in_rs_b = '0, in_rd = '0;
    logic [DW-1:0] in_a = '0, in_b = '0;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [3:0]    flags;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exec_stage #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs_a(in_rs_a), .in_rs_b(in_rs_b), .in_a(in_a),
        .in_b(in_b), .in_rd(in_rd), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .flags(flags)
    );

    task automatic drive(input logic [3:0] op, input logic [AW-1:0] rs_a, input logic [AW-1:0] rs_b,
                         input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [AW-1:0] rd);
        in_valid = 1'b1; in_op = op; in_rs_a = rs_a; in_rs_b = rs_b;
        in_a = a; in_b = b; in_rd = rd;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin $display("FAIL reset_in_ready got=%b exp=0", in_ready); failures++; end
        checks++;
        if ({wb_we, wb_addr, wb_data, flags} !== '0) begin
            $display("FAIL reset_outputs got we=%b addr=%h data=%h flags=%b exp all zero", wb_we, wb_addr, wb_data, flags);
            failures++;
        end
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin $display("FAIL release_in_ready_early got=%b exp=0", in_ready); failures++; end
        tick();
        checks++;
        if (in_ready !== 1'b1) begin $display("FAIL release_in_ready got=%b exp=1", in_ready); failures++; end
    endtask

    task automatic test_add_sub();
        drive(4'd0, 6'd62, 6'd62, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd5);
        tick();
        checks++;
        if ({wb_we, wb_addr} !== {1'b1, 6'd5}) begin $display("FAIL add_we_addr got=%b/%0d exp=1/5", wb_we, wb_addr); failures++; end
        checks++;
        if (wb_data !== 64'd0) begin $display("FAIL add_data got=%h exp=0", wb_data); failures++; end
        checks++;
        if (flags !== 4'b0110) begin $display("FAIL add_flags got=%b exp=0110", flags); failures++; end
        idle();
        tick();
        checks++;
        if (wb_we !== 1'b0) begin $display("FAIL we_single_pulse got=%b exp=0", wb_we); failures++; end
        checks++;
        if (flags !== 4'b0110) begin $display("FAIL flags_hold got=%b exp=0110", flags); failures++; end
        drive(4'd1, 6'd62, 6'd62, 64'h8000_0000_0000_0000, 64'd1, 6'd6);
        tick();
        checks++;
        if (wb_data !== 64'h7FFF_FFFF_FFFF_FFFF) begin $display("FAIL sub_data got=%h exp=7fffffffffffffff", wb_data); failures++; end
        checks++;
        if (flags !== 4'b0011) begin $display("FAIL sub_flags got=%b exp=0011", flags); failures++; end
        idle();
        tick();
    endtask

    task automatic test_alu_ops();
        logic [3:0]  v_op[13];
        logic [63:0] v_a[13];
        logic [63:0] v_b[13];
        logic [63:0] v_r[13];
        logic [3:0]  v_f[13];
        v_op = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8, 4'd9, 4'd0, 4'd1, 4'd1};
        v_a  = '{64'hF0F0, 64'hF0F0, 64'h1234, 64'd1, 64'd1, 64'h8000_0000_0000_0000,
                 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd5,
                 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd5};
        v_b  = '{64'hFF00, 64'h0F0F, 64'h1234, 64'd63, 64'h41, 64'h44, 64'h43, 64'd1,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd2, 64'd5};
        v_r  = '{64'hF000, 64'hFFFF, 64'd0, 64'h8000_0000_0000_0000, 64'd2,
                 64'h0800_0000_0000_0000, 64'hF000_0000_0000_0000, 64'd1, 64'd0,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        v_f  = '{4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000,
                 4'b0100, 4'b1000, 4'b1001, 4'b1000, 4'b0110};
        for (int i = 0; i < 13; i++) begin
            drive(v_op[i], 6'd62, 6'd62, v_a[i], v_b[i], 6'(10 + i));
            tick();
            checks++;
            if ({wb_we, wb_addr} !== {1'b1, 6'(10 + i)}) begin
                $display("FAIL alu%0d_we_addr got=%b/%0d exp=1/%0d", i, wb_we, wb_addr, 10 + i); failures++;
            end
            checks++;
            if (wb_data !== v_r[i]) begin $display("FAIL alu%0d_data got=%h exp=%h", i, wb_data, v_r[i]); failures++; end
            checks++;
            if (flags !== v_f[i]) begin $display("FAIL alu%0d_flags got=%b exp=%b", i, flags, v_f[i]); failures++; end
        end
        idle();
        tick();
    endtask

    task automatic test_nop();
        drive(4'd11, 6'd62, 6'd62, 64'd3, 64'd4, 6'd20);
        tick();
        drive(4'd15, 6'd62, 6'd62, 64'd3, 64'd4, 6'd21);
        checks++;
        if ({wb_we, in_ready, flags} !== {1'b0, 1'b1, 4'b0110}) begin
            $display("FAIL nop11 got we=%b rdy=%b flags=%b exp we=0 rdy=1 flags=0110", wb_we, in_ready, flags); failures++;
        end
        tick();
        checks++;
        if ({wb_we, in_ready, flags} !== {1'b0, 1'b1, 4'b0110}) begin
            $display("FAIL nop15 got we=%b rdy=%b flags=%b exp we=0 rdy=1 flags=0110", wb_we, in_ready, flags); failures++;
        end
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        drive(4'd9, 6'd62, 6'd62, 64'hDEAD, 64'd7, 6'd3);
        tick();
        checks++;
        if ({wb_we, wb_addr, wb_data} !== {1'b1, 6'd3, 64'd7}) begin
            $display("FAIL mov_r3 got we=%b addr=%0d data=%h exp 1/3/7", wb_we, wb_addr, wb_data); failures++;
        end
        drive(4'd0, 6'd3, 6'd61, 64'd0, 64'd1, 6'd4);
        tick();
        checks++;
        if ({wb_addr, wb_data} !== {6'd4, 64'd8}) begin $display("FAIL fwd_a got addr=%0d data=%h exp 4/8", wb_addr, wb_data); failures++; end
        drive(4'd0, 6'd4, 6'd4, 64'd0, 64'd0, 6'd2);
        tick();
        checks++;
        if (wb_data !== 64'd16) begin $display("FAIL fwd_both got=%h exp=10", wb_data); failures++; end
        drive(4'd9, 6'd62, 6'd62, 64'd0, 64'd7, 6'd0);
        tick();
        checks++;
        if ({wb_we, wb_addr, wb_data} !== {1'b1, 6'd0, 64'd7}) begin
            $display("FAIL mov_r0 got we=%b addr=%0d data=%h exp 1/0/7", wb_we, wb_addr, wb_data); failures++;
        end
        drive(4'd0, 6'd0, 6'd61, 64'd0, 64'd1, 6'd1);
        tick();
        checks++;
        if (wb_data !== 64'd1) begin $display("FAIL no_fwd_r0 got=%h exp=1", wb_data); failures++; end
        idle();
        tick();
    endtask

    task automatic test_mul();
        int low_cnt = 0;
        int we_cnt = 0;
        int we_k = 0;
        logic [DW-1:0] got_data = '0;
        logic [AW-1:0] got_addr = '0;
        drive(4'd1, 6'd62, 6'd62, 64'd0, 64'd1, 6'd8);
        tick();
        checks++;
        if (flags !== 4'b1000) begin $display("FAIL sub_borrow_flags got=%b exp=1000", flags); failures++; end
        idle();
        tick();
        drive(4'd10, 6'd62, 6'd62, 64'd123456789, 64'd1000, 6'd7);
        tick();
        idle();
`ifdef EXEC_MUL_EN
        for (int k = 1; k <= 80; k++) begin
            if (in_ready === 1'b0) low_cnt++;
            if (wb_we === 1'b1) begin we_cnt++; we_k = k; got_data = wb_data; got_addr = wb_addr; end
            if (k == 10) drive(4'd0, 6'd62, 6'd62, 64'd1, 64'd1, 6'd9);
            if (k == 11) idle();
            tick();
        end
        checks++;
        if (low_cnt != 64) begin $display("FAIL mul_busy_cycles got=%0d exp=64", low_cnt); failures++; end
        checks++;
        if (we_cnt != 1 || we_k != 65) begin $display("FAIL mul_we got count=%0d at=%0d exp 1 at 65", we_cnt, we_k); failures++; end
        checks++;
        if ({got_addr, got_data} !== {6'd7, 64'd123456789000}) begin
            $display("FAIL mul_result got addr=%0d data=%0d exp 7/123456789000", got_addr, got_data); failures++;
        end
        checks++;
        if (flags !== 4'b0000) begin $display("FAIL mul_flags got=%b exp=0000", flags); failures++; end
`else
        for (int k = 1; k <= 3; k++) begin
            if (in_ready === 1'b0) low_cnt++;
            if (wb_we === 1'b1) we_cnt++;
            tick();
        end
        checks++;
        if (low_cnt != 0 || we_cnt != 0) begin $display("FAIL op10_nop got low=%0d we=%0d exp 0/0", low_cnt, we_cnt); failures++; end
        checks++;
        if (flags !== 4'b1000) begin $display("FAIL op10_flags got=%b exp=1000", flags); failures++; end
`endif
    endtask

    task automatic test_reset_mid_mul();
        int stray = 0;
        drive(4'd1, 6'd62, 6'd62, 64'd0, 64'd1, 6'd8);
        tick();
        drive(4'd10, 6'd62, 6'd62, 64'd123456789, 64'd1000, 6'd7);
        tick();
        idle();
        repeat (29) tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({wb_we, wb_addr, wb_data, flags} !== '0) begin
            $display("FAIL midreset_outputs got we=%b addr=%h data=%h flags=%b exp all zero", wb_we, wb_addr, wb_data, flags);
            failures++;
        end
        checks++;
        if (in_ready !== 1'b0) begin $display("FAIL midreset_in_ready got=%b exp=0", in_ready); failures++; end
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin $display("FAIL midrelease_early got=%b exp=0", in_ready); failures++; end
        tick();
        checks++;
        if (in_ready !== 1'b1) begin $display("FAIL midrelease_in_ready got=%b exp=1", in_ready); failures++; end
        for (int k = 0; k < 80; k++) begin
            if (wb_we === 1'b1) stray++;
            tick();
        end
        checks++;
        if (stray != 0) begin $display("FAIL aborted_mul_write got=%0d exp=0", stray); failures++; end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_alu_ops();
        test_nop();
        test_back_to_back();
        test_mul();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
